// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs a stream of 4-bit nibbles into 16-bit words
// with early close on in_last, a padded tail and a one-word output register.
module nibble_packer #(
  parameter bit         LSB_FIRST  = 1'b1,
  parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_count
);

  typedef enum logic {
    EMPTY   = 1'b0,
    FILLING = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [1:0]  fill_count, fill_next;
  logic [15:0] asm_reg, asm_next;
  logic [15:0] word;
  logic        accept;
  logic        completing;
  logic        load_word;

  // Bit offset of arrival slot k inside the packed word.
  function automatic logic [3:0] slot_offset(input logic [1:0] k);
    logic [1:0] pos;
    pos = LSB_FIRST ? k : (2'd3 - k);
    return {pos, 2'b00};
  endfunction

  // A held word only blocks input while the consumer is stalling it.
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign completing = accept && (in_last || (fill_count == 2'd3));

  // Current nibble goes into its slot; slots beyond it carry the pad value.
  always_comb begin
    word = asm_reg;
    for (int k = 0; k < 4; k++) begin
      if (2'(k) == fill_count) begin
        word[slot_offset(2'(k)) +: 4] = in_data;
      end else if (2'(k) > fill_count) begin
        word[slot_offset(2'(k)) +: 4] = PAD_NIBBLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      fill_count <= 2'd0;
      asm_reg    <= 16'h0000;
    end else begin
      state      <= state_next;
      fill_count <= fill_next;
      asm_reg    <= asm_next;
    end
  end

  always_comb begin
    state_next = state;
    fill_next  = fill_count;
    asm_next   = asm_reg;
    load_word  = 1'b0;
    if (accept) begin
      if (completing) begin
        state_next = EMPTY;
        fill_next  = 2'd0;
        asm_next   = 16'h0000;
        load_word  = 1'b1;
      end else begin
        state_next = FILLING;
        fill_next  = fill_count + 2'd1;
        asm_next   = word;
      end
    end
  end

  // A new word may overwrite one being consumed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_count <= 3'd0;
    end else if (load_word) begin
      out_valid <= 1'b1;
      out_data  <= word;
      out_count <= 3'(fill_count) + 3'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - randomized and directed scoreboard bench for
// nibble_packer, default and MSB-first/padded instances side by side.
module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = 4'h0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [15:0] out_data0, out_data1;
  logic [2:0]  out_count0, out_count1;

  nibble_packer dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_count(out_count0)
  );

  nibble_packer #(.LSB_FIRST(1'b0), .PAD_NIBBLE(4'h5)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_count(out_count1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [2:0]  cnt;
  } word_t;

  word_t       q[$];
  word_t       pend;
  bit          pend_v = 1'b0;
  logic [3:0]  cur[4];
  int          cur_n = 0;
  logic [15:0] last0 = 16'h0, last1 = 16'h0;
  logic [2:0]  last_cnt = 3'd0;
  int          checks = 0;
  int          errors = 0;
  bit          rmode = 1'b0;
  bit          rfix = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Word layout from first principles: arrival index k lands in nibble
  // position k (LSB-first) or 3-k (MSB-first); missing arrivals are pad.
  function automatic logic [15:0] build(input int n, input bit lsb, input logic [3:0] pad);
    logic [15:0] w;
    w = 16'h0;
    for (int k = 0; k < 4; k++) begin
      int pos;
      pos = lsb ? k : 3 - k;
      w = w | (16'((k < n) ? cur[k] : pad) << (4 * pos));
    end
    return w;
  endfunction

  task automatic model_accept(input logic [3:0] d, input logic l);
    cur[cur_n] = d;
    cur_n++;
    if (l || cur_n == 4) begin
      pend.d0  = build(cur_n, 1'b1, 4'h0);
      pend.d1  = build(cur_n, 1'b0, 4'h5);
      pend.cnt = 3'(cur_n);
      pend_v   = 1'b1;
      cur_n    = 0;
    end
  endtask

  // A completed word becomes visible one clock after its accepting edge.
  always @(posedge clk) begin
    #1;
    if (pend_v) begin
      q.push_back(pend);
      pend_v = 1'b0;
    end
  end

  // Monitor: samples settled values 2 time units before each rising edge.
  always @(negedge clk) begin
    #3;
    chk("out_valid0", out_valid0, q.size() != 0);
    chk("out_valid1", out_valid1, q.size() != 0);
    chk("in_ready0", in_ready0, (q.size() == 0) || out_ready);
    chk("in_ready1", in_ready1, (q.size() == 0) || out_ready);
    if (q.size() != 0) begin
      chk("out_data0", out_data0, q[0].d0);
      chk("out_data1", out_data1, q[0].d1);
      chk("out_count0", out_count0, q[0].cnt);
      chk("out_count1", out_count1, q[0].cnt);
      if (out_ready) begin
        last0    = q[0].d0;
        last1    = q[0].d1;
        last_cnt = q[0].cnt;
        void'(q.pop_front());
      end
    end else begin
      chk("hold_data0", out_data0, last0);
      chk("hold_data1", out_data1, last1);
      chk("hold_count0", out_count0, last_cnt);
    end
  end

  task automatic cycle_drive(input bit v, input logic [3:0] d, input logic l, output bit acc);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = rmode ? ($urandom_range(0, 99) < 60) : rfix;
    #1;
    acc = v && in_ready0 && rst_n;
    if (acc) model_accept(d, l);
  endtask

  task automatic send(input logic [3:0] d, input logic l, output int tries);
    bit acc;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      cycle_drive(1'b1, d, l, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic send_seq(input logic [3:0] d0, d1, d2, d3);
    int t;
    send(d0, 1'b0, t);
    send(d1, 1'b0, t);
    send(d2, 1'b0, t);
    send(d3, 1'b0, t);
  endtask

  task automatic idle();
    bit acc;
    cycle_drive(1'b0, 4'($urandom), 1'($urandom), acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || pend_v) && n < 30) begin
      idle();
      n++;
    end
    idle();
    chk("drain", (q.size() == 0 && !pend_v), 1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    q.delete();
    pend_v   = 1'b0;
    cur_n    = 0;
    last0    = 16'h0;
    last1    = 16'h0;
    last_cnt = 3'd0;
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_data", out_data0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    bit acc;
    repeat (2) @(negedge clk);
    chk("init_in_ready", in_ready0, 1);
    chk("init_out_count", out_count0, 0);
    rst_n = 1'b1;
    rmode = 1'b0;
    rfix  = 1'b1;

    send_seq(4'hA, 4'hA, 4'h0, 4'h0);
    drain();
    chk("word_00AA", last0, 16'h00AA);
    chk("word_00AA_cnt", last_cnt, 4);

    send_seq(4'hF, 4'h0, 4'h1, 4'h2);
    drain();
    chk("msb_F012", last1, 16'hF012);

    send(4'h0, 1'b0, t);
    send(4'hF, 1'b1, t);
    drain();
    chk("early_00F0", last0, 16'h00F0);
    chk("early_cnt", last_cnt, 2);
    chk("early_pad_msb", last1, 16'h0F55);
    send_seq(4'hA, 4'hB, 4'hC, 4'hD);
    drain();
    chk("after_early_DCBA", last0, 16'hDCBA);

    send_seq(4'h1, 4'h2, 4'h3, 4'h4);
    rfix = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle_drive(1'b1, 4'h5, 1'b0, acc);
      chk("bp_no_accept", acc, 0);
    end
    rfix = 1'b1;
    send_seq(4'h5, 4'h6, 4'h7, 4'h8);
    drain();
    chk("bp_next_8765", last0, 16'h8765);

    send(4'h9, 1'b0, t);
    send(4'h9, 1'b0, t);
    reset_pulse();
    send_seq(4'h1, 4'h2, 4'h3, 4'h4);
    drain();
    chk("post_rst_4321", last0, 16'h4321);
    chk("post_rst_msb", last1, 16'h1234);

    for (int i = 1; i <= 8; i++) begin
      send(4'(i), 1'b0, t);
      chk("stream_no_bubble", t, 1);
    end
    for (int i = 12; i <= 14; i++) begin
      send(4'(i), 1'b1, t);
      chk("coincident_no_bubble", t, 1);
    end
    drain();
    chk("coincident_last", last0, 16'h000E);
    chk("coincident_cnt", last_cnt, 1);

    rmode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 75) begin
        send(4'($urandom), ($urandom_range(0, 99) < 25), t);
      end else begin
        idle();
      end
      if (i == 200) reset_pulse();
    end
    rmode = 1'b0;
    rfix  = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1: 1 places the first nibble of a word in out_data[3:0]; 0 places it in out_data[15:12].
REQ-002 The block SHALL have parameter PAD_NIBBLE, default 4'h0: the value placed in unfilled nibble slots of a word closed early by in_last.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have the port in_valid, input, 1 bit: a nibble is offered on in_data.
REQ-006 The block SHALL have the port in_ready, output, 1 bit: the block accepts the offered nibble this cycle.
REQ-007 The block SHALL have the port in_data, input, 4 bits: nibble payload.
REQ-008 The block SHALL have the port in_last, input, 1 bit: the offered nibble closes the current word.
REQ-009 The block SHALL have the port out_valid, output, 1 bit: out_data and out_count hold a completed word.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: the consumer takes the word this cycle.
REQ-011 The block SHALL have the port out_data, output, 16 bits: the packed word.
REQ-012 The block SHALL have the port out_count, output, 3 bits: the number of real nibbles in out_data, 1 to 4.

Function
REQ-013 A nibble SHALL be accepted on any rising clk edge where in_valid && in_ready; a word SHALL be consumed on any edge where out_valid && out_ready.
REQ-014 The block SHALL implement an FSM with two states:
- EMPTY: fill count 0.
- FILLING: fill count 1 to 3.
REQ-015 The FSM SHALL make these transitions:
- Accept in EMPTY without completion -> FILLING.
- Completing accept -> EMPTY.
REQ-016 An accept SHALL be completing when it is the 4th nibble or when in_last=1.
REQ-017 On a completing accept, the assembled word, including the current nibble and PAD_NIBBLE in empty slots, SHALL be loaded into the output register with out_count = nibbles in the word, and out_valid SHALL rise on the next cycle; latency is 1 clk from completing accept to out_valid.
REQ-018 Nibble k (k = 0..3, in arrival order) SHALL occupy bits [4k+3:4k] when LSB_FIRST=1 and bits [15-4k:12-4k] when LSB_FIRST=0.
REQ-019 in_ready SHALL be combinational: !out_valid || out_ready; it SHALL NOT depend on in_valid.
REQ-020 A simultaneous word consume and completing accept in the same cycle SHALL cause the new word to replace the old one with out_valid remaining 1, and no word SHALL be lost or duplicated.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_count SHALL hold stable and no nibble SHALL be accepted.
REQ-022 A consume without a new completing accept SHALL clear out_valid on the next cycle; out_data SHALL retain its last value.
REQ-023 in_last on the 4th nibble SHALL behave identically to a normal 4th nibble, with out_count=4.
REQ-024 The fill counter SHALL wrap from 3 to 0 on the 4th accept; no partial state SHALL carry into the next word.
REQ-025 in_data and in_last SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-026 While rst_n=0, the block SHALL force state EMPTY, fill count 0, assembly register 16'h0000, out_valid 0, out_data 16'h0000 and out_count 3'd0, and in_ready SHALL be 1 (since out_valid=0), independent of clk.
REQ-027 Assertion of rst_n mid-word or with a pending output word SHALL discard the partial and pending data; the first accept after release SHALL be nibble 0 of a new word.
REQ-028 Deassertion of rst_n SHALL take effect at the next rising clk edge.

Verification
REQ-029 Default parameters, out_ready=1, nibbles A,A,0,0 -> out_data=16'h00AA, out_count=4, out_valid high for exactly 1 cycle, 1 clk after the 4th accept.
REQ-030 LSB_FIRST=0, nibbles F,0,1,2 -> out_data=16'hF012, out_count=4.
REQ-031 Nibbles 0,F with in_last on F, PAD_NIBBLE=4'h0 -> out_data=16'h00F0, out_count=2; next word A,B,C,D -> 16'hDCBA, out_count=4.
REQ-032 out_ready held 0 for 5 cycles with a word pending -> in_ready=0, out_data stable, no nibble lost; release out_ready -> the pending word is consumed and the next word is assembled correctly.
REQ-033 rst_n pulsed low after 2 nibbles, then nibbles 1,2,3,4 -> out_data=16'h4321, with no contamination from the pre-reset nibbles.
REQ-034 Back-to-back streaming of 8 nibbles with out_ready=1, including a completing accept coincident with a consume -> two words in order, each with out_count=4, and no bubble on the input side.
